// File: rtl/wb_arbiter_pkg.sv
// Shared writeback definitions: register address width, register count and entry layout.
// Entries are packed as {rd[REG_ADDR_W-1:0], data[XLEN-1:0]}.
package wb_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;

    // Width of one {rd, data} writeback entry for a given data width.
    function automatic int entry_w(input int xlen);
        return REG_ADDR_W + xlen;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with a per-entry valid/tag view for hazard tracking.
// Latency: push visible at the head the cycle after the push edge.
// Backpressure: push is ignored while full, even with a same-cycle pop.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0]      entry_vld,
    output logic [DEPTH*RD_W-1:0] entry_rd
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; occupancy is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Slot i is live when its distance from the read pointer is below the count.
    always_comb begin
        entry_vld = '0;
        entry_rd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] offset;
            offset                    = AW'(i) - rd_ptr;
            entry_vld[i]              = ({1'b0, offset} < count);
            entry_rd[i*RD_W +: RD_W]  = mem[i][WIDTH-1 -: RD_W];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter merging ALU results (priority) and buffered loads into one regfile port.
// Latency: ALU 1 cycle, load >= 2 cycles; a waiting load is forced through after STARVE_LIMIT ALU grants.
// Backpressure: ld_ready drops when the load FIFO is full; alu_stall asks the ALU to hold off.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            alu_stall,
    output logic [4:0]      rd,
    output logic            we,
    output logic [XLEN-1:0] wdata,
    output logic [31:0]     pend_mask,
    output logic            err
);
    localparam int EW = entry_w(XLEN);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [EW-1:0]               fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [AW:0]                 fifo_count;
    logic [DEPTH-1:0]            entry_vld;
    logic [DEPTH*REG_ADDR_W-1:0] entry_rd;
    logic [REG_ADDR_W-1:0]       head_rd;
    logic [XLEN-1:0]             head_data;
    logic                        grant_ld;
    logic                        grant_alu;
    logic                        from_ld;
    logic [CW-1:0]               starve_cnt;

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .RD_W  (REG_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ld_valid),
        .din       ({ld_rd, ld_data}),
        .pop       (grant_ld),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .entry_vld (entry_vld),
        .entry_rd  (entry_rd)
    );

    assign head_rd   = fifo_dout[EW-1 -: REG_ADDR_W];
    assign head_data = fifo_dout[XLEN-1:0];
    assign ld_ready  = !fifo_full;
    assign alu_stall = (starve_cnt == CW'(STARVE_LIMIT));

    // A stalled cycle always favours the load, even if the ALU ignores the stall.
    assign grant_ld  = !fifo_empty && (alu_stall || !alu_valid);
    assign grant_alu = alu_valid && !grant_ld;

    always_ff @(posedge clk) begin
        if (reset) begin
            we      <= 1'b0;
            rd      <= '0;
            wdata   <= '0;
            from_ld <= 1'b0;
        end else if (grant_ld) begin
            we      <= (head_rd != '0);
            rd      <= head_rd;
            wdata   <= head_data;
            from_ld <= 1'b1;
        end else if (grant_alu) begin
            we      <= (alu_rd != '0);
            rd      <= alu_rd;
            wdata   <= alu_data;
            from_ld <= 1'b0;
        end else begin
            we      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            if (grant_ld || fifo_count == '0)
                starve_cnt <= '0;
            else if (grant_alu && !alu_stall)
                starve_cnt <= starve_cnt + CW'(1);
            if (alu_valid && alu_stall)
                err <= 1'b1;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i])
                pend_mask[entry_rd[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
        end
        if (we && from_ld)
            pend_mask[rd] = 1'b1;
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LIM   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            alu_stall;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [31:0]     pend_mask;
    logic            err;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .alu_stall (alu_stall),
        .rd        (rd),
        .we        (we),
        .wdata     (wdata),
        .pend_mask (pend_mask),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    // Reference model state
    ent_t            q[$];
    int              m_cnt;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_wdata;
    logic            m_from_ld;
    logic            m_err;

    int n_cmp = 0;
    int n_err = 0;

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_we = 0; m_rd = 0; m_wdata = 0; m_from_ld = 0; m_err = 0;
    endtask

    task automatic model_step(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
        bit stall = (m_cnt == LIM);
        bit room  = (q.size() < DEPTH);
        bit nonempty = (q.size() > 0);
        ent_t e;
        if (av && stall) m_err = 1;
        if (nonempty && (stall || !av)) begin
            e = q.pop_front();
            m_we = (e.rd != 0); m_rd = e.rd; m_wdata = e.data; m_from_ld = 1;
            m_cnt = 0;
        end else if (av) begin
            m_we = (ard != 0); m_rd = ard; m_wdata = ad; m_from_ld = 0;
            m_cnt = nonempty ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
        end else begin
            m_we = 0;
            m_cnt = 0;
        end
        if (lv && room) begin
            e.rd = lrd; e.data = ld;
            q.push_back(e);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        if (m_we && m_from_ld) m[m_rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"},        32'(we),        32'(m_we));
        chk({tag, ".rd"},        32'(rd),        32'(m_rd));
        chk({tag, ".wdata"},     wdata,          m_wdata);
        chk({tag, ".ld_ready"},  32'(ld_ready),  32'(q.size() < DEPTH));
        chk({tag, ".alu_stall"}, 32'(alu_stall), 32'(m_cnt == LIM));
        chk({tag, ".pend_mask"}, pend_mask,      model_mask());
        chk({tag, ".err"},       32'(err),       32'(m_err));
    endtask

    task automatic drive(input string tag, input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ld;
        @(posedge clk);
        model_step(av, ard, ad, lv, lrd, ld);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic rst_cycle(input string tag);
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd30; alu_data = 32'h5555_AAAA;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h6666;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
        model_reset();
        @(posedge clk); @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");
        chk("reset.we_const", 32'(we), 32'd0);
        chk("reset.ld_ready_const", 32'(ld_ready), 32'd1);
        chk("reset.pend_const", pend_mask, 32'd0);

        // ALU only
        drive("alu", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0);
        chk("alu.we", 32'(we), 32'd1);
        chk("alu.rd", 32'(rd), 32'd5);
        chk("alu.wdata", wdata, 32'hDEADBEEF);
        chk("alu.pend", pend_mask, 32'd0);
        idle("alu_idle");

        // Load only
        drive("ld0", 0, 5'd0, '0, 1, 5'd7, 32'h1234);
        chk("ld.t1_pend", 32'(pend_mask[7]), 32'd1);
        chk("ld.t1_we", 32'(we), 32'd0);
        idle("ld1");
        chk("ld.t2_we", 32'(we), 32'd1);
        chk("ld.t2_rd", 32'(rd), 32'd7);
        chk("ld.t2_wdata", wdata, 32'h1234);
        chk("ld.t2_pend", 32'(pend_mask[7]), 32'd1);
        idle("ld2");
        chk("ld.t3_pend", pend_mask, 32'd0);

        // Fill with ALU busy, then full-cycle dequeue must not accept
        for (int k = 0; k < 4; k++)
            drive("fill", 1, 5'd20, $urandom, 1, 5'(10 + k), $urandom);
        chk("fill.ld_ready", 32'(ld_ready), 32'd0);
        drive("fill4", 1, 5'd20, $urandom, 1, 5'd14, 32'h1414);
        chk("fill4.stall", 32'(alu_stall), 32'd1);
        drive("fill5", 0, 5'd0, '0, 1, 5'd14, 32'h1414);
        chk("fill5.no_pass", 32'(pend_mask[14]), 32'd0);
        chk("fill5.rd", 32'(rd), 32'd10);
        chk("fill5.ld_ready", 32'(ld_ready), 32'd1);
        for (int k = 0; k < 4; k++) idle("drain");

        // Starvation: exactly LIM ALU writes, then the load
        drive("stv0", 0, 5'd0, '0, 1, 5'd9, 32'h9999);
        for (int k = 0; k < LIM; k++) begin
            drive("stv_alu", 1, 5'(21 + k), $urandom, 0, 5'd0, '0);
            chk("stv.alu_rd", 32'(rd), 32'(21 + k));
            chk("stv.stall", 32'(alu_stall), 32'(k == LIM - 1));
        end
        drive("stv_ld", 0, 5'd0, '0, 0, 5'd0, '0);
        chk("stv.ld_rd", 32'(rd), 32'd9);
        chk("stv.ld_we", 32'(we), 32'd1);
        chk("stv.cleared", 32'(alu_stall), 32'd0);

        // x0 write and protocol violation
        drive("x0", 1, 5'd0, 32'hFFFF, 0, 5'd0, '0);
        chk("x0.we", 32'(we), 32'd0);
        drive("vio0", 0, 5'd0, '0, 1, 5'd8, 32'h8888);
        for (int k = 0; k < LIM; k++) drive("vio_alu", 1, 5'd22, $urandom, 0, 5'd0, '0);
        drive("vio", 1, 5'd25, 32'hBAD, 0, 5'd0, '0);
        chk("vio.rd", 32'(rd), 32'd8);
        chk("vio.wdata", wdata, 32'h8888);
        chk("vio.err", 32'(err), 32'd1);
        idle("vio_i1"); idle("vio_i2");
        chk("vio.sticky", 32'(err), 32'd1);

        // Reset with three loads buffered
        for (int k = 0; k < 3; k++) drive("pre_rst", 1, 5'd30, $urandom, 1, 5'(3 + k), $urandom);
        chk("pre_rst.pend", pend_mask, 32'h38);
        rst_cycle("mid_rst");
        chk("mid_rst.we", 32'(we), 32'd0);
        chk("mid_rst.ld_ready", 32'(ld_ready), 32'd1);
        chk("mid_rst.pend", pend_mask, 32'd0);
        chk("mid_rst.err", 32'(err), 32'd0);

        // Random traffic, mostly obeying stall, with occasional violations and resets
        for (int n = 0; n < 600; n++) begin
            logic av;
            if (n % 150 == 149) begin
                rst_cycle("rnd_rst");
            end else begin
                if (m_cnt == LIM) av = ($urandom_range(0, 15) == 0);
                else              av = ($urandom_range(0, 99) < 60);
                drive("rnd", av, 5'($urandom_range(0, 31)), $urandom,
                      ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the register file's single write port. It merges single-cycle ALU results, which have priority and no backpressure, with variable-latency load results, which are buffered in a small FIFO. It drives the registered `rd`/`we`/`wdata` triple into the register file and exports a pending-destination mask so decode can detect RAW hazards on in-flight loads. A starvation counter forces a load drain when ALU traffic monopolises the port.

## Interface
Parameters:
- `XLEN`, 32, data width
- `DEPTH`, 4, load FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive ALU grants allowed while a load waits (≥1)

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  FIFO can accept; transfer when `ld_valid && ld_ready`
- `ld_rd`  in  5  load destination register
- `ld_data`  in  XLEN  load result
- `alu_stall`  out  1  upstream must hold `alu_valid=0` this cycle
- `rd`  out  5  to regfile write address
- `we`  out  1  to regfile write enable
- `wdata`  out  XLEN  to regfile write data
- `pend_mask`  out  32  bit i set: load to xi is buffered or being written
- `err`  out  1  sticky protocol-violation flag

## Operation
- **Arbitration each cycle, in priority order:**
  1. `alu_stall=1` with FIFO non-empty: grant the FIFO head.
  2. `alu_valid=1`: grant the ALU.
  3. FIFO non-empty: grant the head.
  4. Otherwise idle.
- **Grant:** the output register loads `{rd, data}` and `we=1`. Idle: `we=0`; `rd`/`wdata` hold.
- **x0 writes:** a granted entry with rd==0 is consumed but drives `we=0`.
- **FIFO:** enqueue on `ld_valid && ld_ready`; dequeue on a head grant. `ld_ready = !full`. There is no pass-through when full, even if a dequeue happens in the same cycle. Simultaneous enqueue and dequeue when non-full keeps the count unchanged. Pointers wrap modulo DEPTH.
- **Starvation counter `starve_cnt`** (0..STARVE_LIMIT):
  - +1 on a cycle with an ALU grant while the FIFO is non-empty.
  - Cleared on any dequeue or when the FIFO is empty.
  - `alu_stall = (starve_cnt == STARVE_LIMIT)`.
- **Violation:** `alu_valid=1` while `alu_stall=1`. The ALU result is dropped, the load is still granted, and `err` is set until reset.
- **`pend_mask`:** OR of one-hot(`rd`) over valid FIFO entries, plus one-hot(`rd`) of the output register when `we=1` and that entry came from the load path. Bit 0 is forced to 0. Combinational from registered state.

## Timing
- **Reset values:** `we=0`, `rd=0`, `wdata=0`, `alu_stall=0`, `err=0`, `pend_mask=0`, FIFO empty (`ld_ready=1`), `starve_cnt=0`.
- **Reset mid-operation:** buffered loads are discarded and the output write in progress is suppressed from the next cycle.
- **ALU latency:** result presented in cycle t gives `we=1` in t+1; the regfile is updated at the edge closing t+1.
- **Load latency:** minimum 2 cycles (enqueue edge t, head granted t+1, `we=1` in t+2). Longer under ALU traffic.
- **Stall bound:** with continuous ALU traffic, a waiting load is written at most STARVE_LIMIT+2 cycles after reaching the FIFO head.

## Structure
- **Shared header `wb_defs`:** `XLEN`, `REG_ADDR_W=5`, `NUM_REGS=32`, and the entry layout `{rd[4:0], data[XLEN-1:0]}` with its width macro, reused by decode and the load unit.
- **Sub-module `wb_fifo`:** generic synchronous FIFO (`WIDTH`, `DEPTH`) exposing push/pop/full/empty/count and a per-entry valid+rd view for `pend_mask`.
- **Top level:** arbiter, starvation counter, output register, mask logic.

## Test plan
- **ALU only:** `alu_valid` with rd=5, data=0xDEADBEEF at t → `we=1`, `rd=5`, `wdata=0xDEADBEEF` at t+1; `pend_mask=0` throughout.
- **Load only:** `ld_rd=7`, `ld_data=0x1234` accepted at t → `pend_mask[7]=1` from t+1 through t+2; `we=1`, `rd=7` at t+2; mask clear at t+3.
- **Fill and backpressure:** 4 loads with ALU busy every cycle → `ld_ready=0` after the 4th. Dequeue then enqueue in the same cycle must not accept while full.
- **Starvation:** one load buffered, ALU valid every cycle → 4 ALU writes, then `alu_stall=1` for exactly one cycle, the load written next, and `starve_cnt` cleared.
- **x0 and violation:** ALU rd=0 → `we=0`. `alu_valid=1` during `alu_stall` → load written, ALU dropped, `err=1` sticky.
- **Reset mid-operation:** reset with 3 loads buffered → next cycle `we=0`, `ld_ready=1`, `pend_mask=0`, `err=0`.
